// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type and protocol constants
// for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam int         PS2_DATA_BITS  = 8;

    // True when data plus parity carries an odd number of ones.
    function automatic logic odd_parity_ok(
        input logic [7:0] d,
        input logic       p
    );
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: PS/2 line inputs and scancode/interrupt
// outputs of the keyboard receiver.
interface ps2_keyboard_rx_if;

    logic       PS2CLK;
    logic       PS2DATA;
    logic [7:0] SCANCODE;
    logic       INTRPT;
    logic       ERR;

    modport master (
        output PS2CLK,
        output PS2DATA,
        input  SCANCODE,
        input  INTRPT,
        input  ERR
    );

    modport slave (
        input  PS2CLK,
        input  PS2DATA,
        output SCANCODE,
        output INTRPT,
        output ERR
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: multi-flop synchroniser with a registered
// falling-edge strobe; level is delayed to line up with fe.
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fe
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            prev <= 1'b1;
            fe   <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
            fe   <= prev & ~sync[STAGES-1];
        end
    end

    assign level = prev;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host frame receiver with stretched
// interrupt. Optional make-code-only filter: PS2_BREAK_FILTER_EN.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TIMEOUT_US  = 200,
    parameter int INTR_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic              CLK,
    input logic              RST_N,
    ps2_keyboard_rx_if.slave bus
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);
    localparam logic [7:0] STRETCH = 8'(INTR_CYCLES - 1);

    logic fe;
    logic din;
    logic clk_lvl_unused;
    logic data_fe_unused;

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (bus.PS2CLK),
        .level (clk_lvl_unused),
        .fe    (fe)
    );

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (bus.PS2DATA),
        .level (din),
        .fe    (data_fe_unused)
    );

    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] wd;
    logic [7:0]    intr_cnt;
    logic [7:0]    scancode;
    logic          intrpt;
    logic          err;
`ifdef PS2_BREAK_FILTER_EN
    logic          brk;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            wd       <= '0;
            intr_cnt <= '0;
            scancode <= 8'h00;
            intrpt   <= 1'b0;
            err      <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk      <= 1'b0;
`endif
        end else begin
            err <= 1'b0;
            // Stretch countdown; an accept below restarts it.
            if (intr_cnt != '0) intr_cnt <= intr_cnt - 8'd1;
            else                intrpt   <= 1'b0;
            if (state == IDLE || fe) wd <= '0;
            else                     wd <= wd + 1'b1;
            if (fe) begin
                unique case (state)
                    IDLE: begin
                        if (!din) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= din;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (din && odd_parity_ok(shift, par)) begin
`ifdef PS2_BREAK_FILTER_EN
                            if (brk) begin
                                brk <= 1'b0;
                            end else if (shift == PS2_BREAK_CODE) begin
                                brk <= 1'b1;
                            end else begin
                                scancode <= shift;
                                intrpt   <= 1'b1;
                                intr_cnt <= STRETCH;
                            end
`else
                            scancode <= shift;
                            intrpt   <= 1'b1;
                            intr_cnt <= STRETCH;
`endif
                        end else begin
                            err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            brk <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && wd == WD_MAX) begin
                state <= IDLE;
                err   <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                brk   <= 1'b0;
`endif
            end
        end
    end

    assign bus.SCANCODE = scancode;
    assign bus.INTRPT   = intrpt;
    assign bus.ERR      = err;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the top-level MMIO wrapper. It deserialises 11-bit PS/2 device-to-host frames and presents the last valid scancode on SCANCODE, which the wrapper maps into the keyboard MMIO read address. It raises a stretched interrupt pulse INTRPT that drives the CPU interrupt input. It runs on the 100 MHz board clock, and the pulse is stretched so that the 50 MHz CPU domain reliably samples it.

Parameters:
CLK_FREQ_HZ, 100000000, frequency of CLK; used to derive the watchdog count.
TIMEOUT_US, 200, maximum gap between PS2CLK falling edges inside a frame before the frame is abandoned.
INTR_CYCLES, 4, CLK cycles that INTRPT stays high per accepted scancode; legal range 2 to 255.
SYNC_STAGES, 2, flip-flop depth of the PS2CLK and PS2DATA synchronisers; minimum 2.

Ports:
CLK      in   1  board clock, 100 MHz; all logic on the rising edge.
RST_N    in   1  asynchronous, active-low reset.
PS2CLK   in   1  raw PS/2 clock line from the keyboard (asynchronous).
PS2DATA  in   1  raw PS/2 data line from the keyboard (asynchronous).
SCANCODE out  8  last accepted scancode; held until the next accepted one.
INTRPT   out  1  high for INTR_CYCLES cycles per accepted scancode.
ERR      out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset values: SCANCODE = 8'h00, INTRPT = 0, ERR = 0, FSM = IDLE, all counters = 0.
- Input conditioning:
  - PS2CLK and PS2DATA each pass through SYNC_STAGES flip-flops; synchroniser reset value is 1 (idle bus).
  - A falling edge (fe) is a 1->0 transition on the synchronised PS2CLK; fe is asserted for one cycle.
  - Data is sampled only on fe.
- FSM states:
  - IDLE: on fe with data = 0 (start bit) -> DATA, bit count = 0. On fe with data = 1, stay in IDLE, no ERR.
  - DATA: on each fe, shift data into shift[7:0] LSB-first. After the 8th bit -> PARITY.
  - PARITY: on fe, capture the parity bit -> STOP.
  - STOP: on fe:
    - stop = 1 and odd parity holds (ones in data + parity is odd): accept the frame -> IDLE.
    - Otherwise: ERR pulse, discard the frame -> IDLE.
- Accept action:
  - In the cycle after the stop-bit fe, SCANCODE takes the new byte and INTRPT goes high.
  - INTRPT then stays high for exactly INTR_CYCLES cycles.
  - Latency from the raw PS2CLK stop-bit falling edge to INTRPT high is SYNC_STAGES + 2 cycles.
- Watchdog:
  - The counter clears on every fe and in IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES = CLK_FREQ_HZ/1000000*TIMEOUT_US in any non-IDLE state: FSM -> IDLE, ERR pulses once, SCANCODE is unchanged.
- Accept while INTRPT is already high: SCANCODE updates and the stretch counter restarts at INTR_CYCLES. INTRPT stays continuously high and there is no glitch low.
- An ERR event never modifies SCANCODE or INTRPT.
- Reset asserted mid-frame: all state clears immediately. The partial frame is lost, and the next start bit begins a fresh frame.

Optional Feature:
Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - An accepted byte 8'hF0 sets break_pending and raises no INTRPT; SCANCODE is unchanged.
  - The next accepted byte clears break_pending and is silently consumed (no SCANCODE update, no INTRPT).
  - An ERR or timeout also clears break_pending.
  - 8'hE0 is treated as an ordinary byte.
  - Net effect: only make codes interrupt the CPU.
- Undefined: every accepted byte, including F0, updates SCANCODE and raises INTRPT. No break_pending register exists.

Decomposition:
- Package ps2_pkg holds:
  - state enum ps2_state_t {IDLE, DATA, PARITY, STOP};
  - constants PS2_BREAK_CODE = 8'hF0, PS2_EXT_CODE = 8'hE0, PS2_DATA_BITS = 8.
- Sub-module ps2_sync_edge: parameterised synchroniser plus falling-edge detector. It is instantiated once each for PS2CLK (edge output used) and PS2DATA (level output only).

Test Plan:
1. Frame for 0x1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS2CLK -> SCANCODE = 8'h1C; INTRPT high exactly 4 cycles, starting SYNC_STAGES+2 cycles after the stop edge; ERR never asserted.
2. Same frame with parity bit 1 -> ERR single-cycle pulse after the stop edge; SCANCODE stays 8'h00; INTRPT stays 0.
3. Five bits of a frame, then PS2CLK held high -> after TIMEOUT_CYCLES (20000) one ERR pulse, FSM back in IDLE; a following valid 0x32 frame yields SCANCODE = 8'h32 and an INTRPT pulse.
4. Bytes F0 then 1C: with PS2_BREAK_FILTER_EN, zero INTRPT pulses and SCANCODE unchanged. Without it, two INTRPT pulses, and SCANCODE ends at 8'h1C.
5. RST_N pulsed low after the 4th data bit, then a valid 0x45 frame -> outputs zero during reset; SCANCODE = 8'h45 with one INTRPT pulse afterwards.
6. INTR_CYCLES = 200 with a shortened test frame period so that a second frame (0x29) completes while INTRPT is still high -> INTRPT never drops between frames, stays high 200 cycles after the second accept, and SCANCODE = 8'h29.
